// File: rtl/keypad_bcd_entry_pkg.sv
// Shared definitions for the keypad BCD entry path: FSM states,
// function-key codes and the (row, col) to key-code map.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESS    = 2'd2,
        ST_RELEASE  = 2'd3
    } kp_state_t;

    localparam logic [3:0] KEY_A = 4'hA;
    localparam logic [3:0] KEY_B = 4'hB;
    localparam logic [3:0] KEY_C = 4'hC;
    localparam logic [3:0] KEY_D = 4'hD;
    localparam logic [3:0] KEY_E = 4'hE;
    localparam logic [3:0] KEY_F = 4'hF;

    // PmodKYPD layout: r0 = 1 2 3 A, r1 = 4 5 6 B, r2 = 7 8 9 C, r3 = 0 F E D
    function automatic logic [3:0] key_map(input logic [1:0] row_idx,
                                           input logic [1:0] col_idx);
        logic [3:0] code;
        code = 4'h0;
        case ({row_idx, col_idx})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = KEY_A;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = KEY_B;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = KEY_C;
            4'hC: code = 4'h0;
            4'hD: code = KEY_F;
            4'hE: code = KEY_E;
            default: code = KEY_D;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_bcd_entry_row_sync.sv
// Two-flop synchronizer for the asynchronous, active-low keypad rows.
// Resets to all-ones so the rows look idle (no key) coming out of reset.
module keypad_row_sync (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] din,
    output logic [3:0] dout
);

    logic [3:0] sync_p0;
    logic [3:0] sync_p1;

    // Two-stage capture of the raw row levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 4'hF;
            sync_p1 <= 4'hF;
        end else begin
            sync_p0 <= din;
            sync_p1 <= sync_p0;
        end
    end

    assign dout = sync_p1;

endmodule

// File: rtl/keypad_bcd_entry.sv
// 4x4 keypad scanner with debounce, key encoding and a packed BCD
// entry register. Decimal keys shift into the entry; A-F are code-only.
module keypad_bcd_entry
    import keypad_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            row_n,
    output logic [3:0]            col_n,
    input  logic                  clear,
    output logic [4*DIGITS-1:0]   digits,
    output logic                  key_valid,
    output logic [3:0]            key_code,
    output logic                  overflow
);

    localparam int EW = 4 * DIGITS;
    localparam int TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam int NW = $clog2(DIGITS + 1);

    localparam logic [TW-1:0] TIMER_LAST = TW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEB_TARGET = CW'(DEBOUNCE);
    localparam logic [NW-1:0] ENTRY_FULL = NW'(DIGITS);

    logic [3:0]    row_s;
    logic [TW-1:0] timer;
    logic          tick;

    kp_state_t     state, state_nxt;
    logic [1:0]    col_idx, col_nxt;
    logic [1:0]    row_idx, row_idx_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [3:0]    code_q, code_nxt;

    logic [3:0]    row_low;
    logic          one_low;
    logic [1:0]    row_enc;
    logic [3:0]    row_pat;

    logic [EW-1:0] entry_q;
    logic [NW-1:0] entry_cnt;
    logic          ovf_q;

    keypad_row_sync u_row_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (row_n),
        .dout (row_s)
    );

    // Free-running column window timer; tick marks the sampling cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (tick) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    assign tick = (timer == TIMER_LAST);

    // Classify the synchronized row sample: exactly one row low and which one.
    always_comb begin
        row_low = ~row_s;
        one_low = (row_low != 4'd0) && ((row_low & (row_low - 4'd1)) == 4'd0);
        row_enc = 2'd0;
        case (row_low)
            4'b0010: row_enc = 2'd1;
            4'b0100: row_enc = 2'd2;
            4'b1000: row_enc = 2'd3;
            default: row_enc = 2'd0;
        endcase
        row_pat = ~(4'b0001 << row_idx);
    end

    // Scan FSM state and its companion registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_SCAN;
            col_idx <= 2'd0;
            row_idx <= 2'd0;
            cnt     <= '0;
            code_q  <= 4'h0;
        end else begin
            state   <= state_nxt;
            col_idx <= col_nxt;
            row_idx <= row_idx_nxt;
            cnt     <= cnt_nxt;
            code_q  <= code_nxt;
        end
    end

    // Next-state logic: scan columns, debounce the press, wait for release.
    always_comb begin
        state_nxt   = state;
        col_nxt     = col_idx;
        row_idx_nxt = row_idx;
        cnt_nxt     = cnt;
        code_nxt    = code_q;
        case (state)
            ST_SCAN: begin
                if (tick) begin
                    if (one_low) begin
                        row_idx_nxt = row_enc;
                        cnt_nxt     = CW'(1);
                        if (DEB_TARGET == CW'(1)) begin
                            state_nxt = ST_PRESS;
                            code_nxt  = key_map(row_enc, col_idx);
                        end else begin
                            state_nxt = ST_DEBOUNCE;
                        end
                    end else begin
                        col_nxt = col_idx + 2'd1;
                    end
                end
            end
            ST_DEBOUNCE: begin
                if (tick) begin
                    if (row_s == row_pat) begin
                        cnt_nxt = cnt + 1'b1;
                        if (cnt_nxt == DEB_TARGET) begin
                            state_nxt = ST_PRESS;
                            code_nxt  = key_map(row_idx, col_idx);
                        end
                    end else begin
                        state_nxt = ST_SCAN;
                        col_nxt   = col_idx + 2'd1;
                        cnt_nxt   = '0;
                    end
                end
            end
            ST_PRESS: begin
                state_nxt = ST_RELEASE;
                cnt_nxt   = '0;
            end
            ST_RELEASE: begin
                if (tick) begin
                    if (row_s == 4'hF) begin
                        cnt_nxt = cnt + 1'b1;
                        if (cnt_nxt == DEB_TARGET) begin
                            state_nxt = ST_SCAN;
                            col_nxt   = 2'd0;
                            cnt_nxt   = '0;
                        end
                    end else begin
                        cnt_nxt = '0;
                    end
                end
            end
            default: begin
                state_nxt = ST_SCAN;
                col_nxt   = 2'd0;
                cnt_nxt   = '0;
            end
        endcase
    end

    // BCD entry register: clear wins over a same-cycle decimal press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_q   <= '0;
            entry_cnt <= '0;
            ovf_q     <= 1'b0;
        end else if (clear) begin
            entry_q   <= '0;
            entry_cnt <= '0;
            ovf_q     <= 1'b0;
        end else if (key_valid && (code_q <= 4'd9)) begin
            if (entry_cnt < ENTRY_FULL) begin
                entry_q   <= (entry_q << 4) | EW'(code_q);
                entry_cnt <= entry_cnt + 1'b1;
            end else begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign col_n     = ~(4'b0001 << col_idx);
    assign key_valid = (state == ST_PRESS);
    assign key_code  = code_q;
    assign digits    = entry_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_keypad_bcd_entry.sv
// Bench for keypad_bcd_entry with a small physical keypad model.
module tb_keypad_bcd_entry;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic        clear = 1'b0;
    logic [15:0] digits;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        overflow;

    logic [15:0] keys = 16'h0;       // keys[r*4+c] = key at (r,c) held
    logic [3:0]  force_low = 4'h0;   // rows pulled low regardless of column
    logic [3:0]  row_phys;

    int n_checks = 0;
    int n_fail = 0;
    int pulse_cnt = 0;

    int keymap [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{0, 15, 14, 13}};

    keypad_bcd_entry #(.DIGITS(4), .SCAN_DIV(4), .DEBOUNCE(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .row_n    (row_n),
        .col_n    (col_n),
        .clear    (clear),
        .digits   (digits),
        .key_valid(key_valid),
        .key_code (key_code),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    always_comb begin
        row_phys = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !col_n[c]) row_phys[r] = 1'b0;
            end
        end
    end

    assign row_n = row_phys & ~force_low;

    always @(negedge clk) begin
        if (key_valid === 1'b1) pulse_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout reached");
        $fatal(1, "watchdog");
    end

    task automatic do_press(input int r, input int c, output int pulses);
        int start;
        start = pulse_cnt;
        keys[r*4+c] = 1'b1;
        repeat (100) @(negedge clk);
        keys[r*4+c] = 1'b0;
        repeat (30) @(negedge clk);
        pulses = pulse_cnt - start;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (col_n !== 4'b1110 || digits !== 16'h0 || key_valid !== 1'b0 ||
            overflow !== 1'b0 || key_code !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_outputs col=%b dig=%h kv=%b ovf=%b code=%h want 1110 0000 0 0 0",
                     col_n, digits, key_valid, overflow, key_code);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++;
        if (col_n !== 4'b1101) begin
            n_fail++;
            $display("FAIL reset_rotate1 got %b want 1101", col_n);
        end
        repeat (4) @(negedge clk);
        n_checks++;
        if (col_n !== 4'b1011) begin
            n_fail++;
            $display("FAIL reset_rotate2 got %b want 1011", col_n);
        end
    endtask

    task automatic test_single_key();
        int start;
        int waited;
        start = pulse_cnt;
        keys[1*4+1] = 1'b1;
        repeat (100) @(negedge clk);
        n_checks++;
        if (col_n !== 4'b1101) begin
            n_fail++;
            $display("FAIL single_col_frozen got %b want 1101", col_n);
        end
        keys[1*4+1] = 1'b0;
        waited = 0;
        while (col_n === 4'b1101 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (col_n !== 4'b1110) begin
            n_fail++;
            $display("FAIL single_release_col got %b want 1110", col_n);
        end
        repeat (20) @(negedge clk);
        n_checks++;
        if (pulse_cnt - start !== 1) begin
            n_fail++;
            $display("FAIL single_pulses got %0d want 1", pulse_cnt - start);
        end
        n_checks++;
        if (key_code !== 4'h5 || digits !== 16'h0005) begin
            n_fail++;
            $display("FAIL single_value code=%h dig=%h want 5 0005", key_code, digits);
        end
    endtask

    task automatic test_full_entry();
        int p;
        int rc [5][2] = '{'{0, 0}, '{0, 1}, '{0, 2}, '{1, 0}, '{1, 1}};
        pulse_clear();
        n_checks++;
        if (digits !== 16'h0) begin
            n_fail++;
            $display("FAIL full_pre_clear got %h want 0000", digits);
        end
        for (int i = 0; i < 5; i++) begin
            do_press(rc[i][0], rc[i][1], p);
            n_checks++;
            if (p !== 1 || key_code !== 4'(i + 1)) begin
                n_fail++;
                $display("FAIL full_key%0d pulses=%0d code=%h want 1 %0d", i + 1, p, key_code, i + 1);
            end
            if (i == 3) begin
                n_checks++;
                if (digits !== 16'h1234 || overflow !== 1'b0) begin
                    n_fail++;
                    $display("FAIL full_four dig=%h ovf=%b want 1234 0", digits, overflow);
                end
            end
        end
        n_checks++;
        if (digits !== 16'h1234 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL full_overflow dig=%h ovf=%b want 1234 1", digits, overflow);
        end
        pulse_clear();
        n_checks++;
        if (digits !== 16'h0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL full_clear dig=%h ovf=%b want 0000 0", digits, overflow);
        end
    endtask

    task automatic test_bounce();
        int start;
        int waited;
        int changes;
        logic [3:0] prev;
        start = pulse_cnt;
        waited = 0;
        while (col_n === 4'b1110 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        while (col_n !== 4'b1110 && waited < 80) begin
            @(negedge clk);
            waited++;
        end
        force_low = 4'b0001;
        repeat (4) @(negedge clk);
        n_checks++;
        if (col_n !== 4'b1110) begin
            n_fail++;
            $display("FAIL bounce_frozen got %b want 1110", col_n);
        end
        force_low = 4'b0000;
        repeat (4) @(negedge clk);
        n_checks++;
        if (col_n !== 4'b1101) begin
            n_fail++;
            $display("FAIL bounce_next_col got %b want 1101", col_n);
        end
        repeat (20) @(negedge clk);
        n_checks++;
        if (pulse_cnt - start !== 0) begin
            n_fail++;
            $display("FAIL bounce_pulses got %0d want 0", pulse_cnt - start);
        end
        start = pulse_cnt;
        force_low = 4'b0101;
        changes = 0;
        prev = col_n;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (col_n !== prev) changes++;
            prev = col_n;
        end
        force_low = 4'b0000;
        repeat (20) @(negedge clk);
        n_checks++;
        if (pulse_cnt - start !== 0 || changes < 9) begin
            n_fail++;
            $display("FAIL two_rows pulses=%0d col_changes=%0d want 0 >=9", pulse_cnt - start, changes);
        end
    endtask

    task automatic test_function_and_clear();
        int p;
        int waited;
        logic seen;
        do_press(2, 1, p);
        n_checks++;
        if (p !== 1 || digits !== 16'h0008) begin
            n_fail++;
            $display("FAIL func_pre pulses=%0d dig=%h want 1 0008", p, digits);
        end
        do_press(0, 3, p);
        n_checks++;
        if (p !== 1 || key_code !== 4'hA || digits !== 16'h0008 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL func_keyA pulses=%0d code=%h dig=%h ovf=%b want 1 a 0008 0",
                     p, key_code, digits, overflow);
        end
        keys[2*4+0] = 1'b1;
        waited = 0;
        seen = 1'b0;
        while (!seen && waited < 80) begin
            @(negedge clk);
            waited++;
            if (key_valid === 1'b1) seen = 1'b1;
        end
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        n_checks++;
        if (!seen || key_code !== 4'h7 || digits !== 16'h0) begin
            n_fail++;
            $display("FAIL clear_in_press seen=%b code=%h dig=%h want 1 7 0000", seen, key_code, digits);
        end
        repeat (60) @(negedge clk);
        keys[2*4+0] = 1'b0;
        repeat (30) @(negedge clk);
    endtask

    task automatic test_random_entry();
        logic [15:0] m_dig;
        int m_cnt;
        logic m_ovf;
        int r, c, code, p;
        pulse_clear();
        m_dig = 16'h0;
        m_cnt = 0;
        m_ovf = 1'b0;
        for (int i = 0; i < 12; i++) begin
            r = int'($urandom_range(0, 3));
            c = int'($urandom_range(0, 3));
            code = keymap[r][c];
            if (code <= 9) begin
                if (m_cnt < 4) begin
                    m_dig = (m_dig << 4) | 16'(code);
                    m_cnt++;
                end else begin
                    m_ovf = 1'b1;
                end
            end
            do_press(r, c, p);
            n_checks++;
            if (p !== 1 || key_code !== 4'(code) || digits !== m_dig || overflow !== m_ovf) begin
                n_fail++;
                $display("FAIL random_%0d key(%0d,%0d) pulses=%0d code=%h dig=%h ovf=%b want 1 %h %h %b",
                         i, r, c, p, key_code, digits, overflow, 4'(code), m_dig, m_ovf);
            end
        end
        pulse_clear();
    endtask

    task automatic test_mid_reset();
        int p;
        int start;
        int waited;
        do_press(0, 2, p);
        n_checks++;
        if (p !== 1 || digits !== 16'h0003) begin
            n_fail++;
            $display("FAIL midrst_pre pulses=%0d dig=%h want 1 0003", p, digits);
        end
        start = pulse_cnt;
        keys[1*4+1] = 1'b1;
        waited = 0;
        while (col_n !== 4'b1101 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (col_n !== 4'b1110 || digits !== 16'h0 || key_valid !== 1'b0 ||
            overflow !== 1'b0 || key_code !== 4'h0) begin
            n_fail++;
            $display("FAIL midrst_async col=%b dig=%h kv=%b ovf=%b code=%h want 1110 0000 0 0 0",
                     col_n, digits, key_valid, overflow, key_code);
        end
        @(negedge clk);
        keys[1*4+1] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        n_checks++;
        if (pulse_cnt - start !== 0 || digits !== 16'h0) begin
            n_fail++;
            $display("FAIL midrst_no_key pulses=%0d dig=%h want 0 0000", pulse_cnt - start, digits);
        end
    endtask

    initial begin
        test_reset();
        test_single_key();
        test_full_entry();
        test_bounce();
        test_function_and_clear();
        test_random_entry();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
